// File: rtl/brief_pkg.sv
// Shared types and helpers for the BRIEF line-buffer sequencer.
`timescale 1ns/1ps
package brief_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WORK,
    DRAIN
  } state_t;

  localparam int COOR_W = 10;
  localparam int ADDR_W = 10;

  function automatic int fill_len(input int width, input int radius);
    return radius * width + radius;
  endfunction

endpackage

// File: rtl/brief_ring_addr.sv
// WIDTH-modulo SRAM ring addresses: write (port A) and leading read (port B).
`timescale 1ns/1ps
module brief_ring_addr
  import brief_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int RD_LEAD = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_aa,
  output logic [ADDR_W-1:0] o_ab
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W:0]   WID  = (ADDR_W+1)'(WIDTH);
  localparam logic [ADDR_W:0]   LEAD = (ADDR_W+1)'(RD_LEAD % WIDTH);

  logic [ADDR_W-1:0] aa_n;
  logic [ADDR_W:0]   sum;

  always_comb begin
    aa_n = (o_aa == LAST) ? '0 : o_aa + 1'b1;
    sum  = {1'b0, aa_n} + LEAD;
    if (sum >= WID)
      sum = sum - WID;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_aa <= '0;
      o_ab <= '0;
    end else if (i_clr) begin
      o_aa <= '0;
      o_ab <= LEAD[ADDR_W-1:0];
    end else if (i_adv) begin
      o_aa <= aa_n;
      o_ab <= sum[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/brief_lb_ctrl.sv
// BRIEF line-buffer sequencer: shift strobe, ring addresses, window-centre
// tracking through fill/work/drain, and frame markers.
`timescale 1ns/1ps
module brief_lb_ctrl
  import brief_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int RADIUS  = 15,
  parameter int RD_LEAD = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pixel_valid,
  output logic              o_shift_en,
  output logic              o_sram_wen,
  output logic [ADDR_W-1:0] o_sram_aa,
  output logic [ADDR_W-1:0] o_sram_ab,
  output logic              o_win_valid,
  output logic [COOR_W-1:0] o_coor_x,
  output logic [COOR_W-1:0] o_coor_y,
  output logic              o_border,
  output logic              o_start,
  output logic              o_end,
  output logic              o_busy,
  output logic              o_err
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0]  FILL_C = CNT_W'(fill_len(WIDTH, RADIUS));
  localparam logic [CNT_W-1:0]  TOT_C  = CNT_W'(TOTAL);
  localparam logic [COOR_W-1:0] X_LAST = COOR_W'(WIDTH - 1);
  localparam logic [COOR_W-1:0] Y_LAST = COOR_W'(HEIGHT - 1);
  localparam logic [COOR_W-1:0] LO     = COOR_W'(RADIUS);
  localparam logic [COOR_W-1:0] X_HI   = COOR_W'(WIDTH - 1 - RADIUS);
  localparam logic [COOR_W-1:0] Y_HI   = COOR_W'(HEIGHT - 1 - RADIUS);

  state_t state, state_n;

  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [COOR_W-1:0] cx, cy, cx_n, cy_n;
  logic take, busy, restart, clr;
  logic shift, emit, last, border;

  assign take    = i_start & i_pixel_valid;
  assign busy    = (state != IDLE);
  assign restart = take & busy;
  assign cnt_inc = cnt + 1'b1;
  assign last    = (cx == X_LAST) && (cy == Y_LAST);
  assign border  = (cx < LO) || (cx > X_HI) ||
                   (cy < LO) || (cy > Y_HI);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cx_n    = cx;
    cy_n    = cy;
    shift   = 1'b0;
    emit    = 1'b0;
    clr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          shift = 1'b1;
          clr   = 1'b1;
        end
      end
      FILL: begin
        if (i_pixel_valid) begin
          shift = 1'b1;
          cnt_n = cnt_inc;
          if (cnt_inc == FILL_C)
            state_n = WORK;
        end
      end
      WORK: begin
        if (i_pixel_valid) begin
          shift = 1'b1;
          emit  = 1'b1;
          cnt_n = cnt_inc;
          if (cnt_inc == TOT_C)
            state_n = DRAIN;
        end
      end
      DRAIN: begin
        shift = 1'b1;
        emit  = 1'b1;
        if (last)
          state_n = IDLE;
      end
      default: ;
    endcase
    // A restart pixel aborts the frame and becomes pixel 1 of the next.
    if (restart) begin
      clr  = 1'b1;
      emit = 1'b0;
    end
    if (clr) begin
      state_n = FILL;
      cnt_n   = CNT_W'(1);
      cx_n    = '0;
      cy_n    = '0;
    end else if (emit) begin
      if (cx == X_LAST) begin
        cx_n = '0;
        cy_n = cy + 1'b1;
      end else begin
        cx_n = cx + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cx          <= '0;
      cy          <= '0;
      o_win_valid <= 1'b0;
      o_coor_x    <= '0;
      o_coor_y    <= '0;
      o_border    <= 1'b0;
      o_start     <= 1'b0;
      o_end       <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cx          <= cx_n;
      cy          <= cy_n;
      o_win_valid <= emit;
      o_start     <= emit && (cx == '0) && (cy == '0);
      o_end       <= restart | (emit & last);
      o_err       <= restart;
      if (emit) begin
        o_coor_x <= cx;
        o_coor_y <= cy;
        o_border <= border;
      end
    end
  end

  brief_ring_addr #(
    .WIDTH   (WIDTH),
    .RD_LEAD (RD_LEAD)
  ) u_ring (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (clr),
    .i_adv   (shift),
    .o_aa    (o_sram_aa),
    .o_ab    (o_sram_ab)
  );

  assign o_shift_en = shift;
  assign o_sram_wen = ~shift;
  assign o_busy     = busy;

endmodule

// File: tb/tb_brief_lb_ctrl.sv
// Scoreboard bench for brief_lb_ctrl on an 8x6 frame, radius 1.
`timescale 1ns/1ps
module tb_brief_lb_ctrl;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_pixel_valid;
  logic       o_shift_en;
  logic       o_sram_wen;
  logic [9:0] o_sram_aa;
  logic [9:0] o_sram_ab;
  logic       o_win_valid;
  logic [9:0] o_coor_x;
  logic [9:0] o_coor_y;
  logic       o_border;
  logic       o_start;
  logic       o_end;
  logic       o_busy;
  logic       o_err;

  brief_lb_ctrl #(
    .WIDTH   (8),
    .HEIGHT  (6),
    .RADIUS  (1),
    .RD_LEAD (2)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_pixel_valid (i_pixel_valid),
    .o_shift_en    (o_shift_en),
    .o_sram_wen    (o_sram_wen),
    .o_sram_aa     (o_sram_aa),
    .o_sram_ab     (o_sram_ab),
    .o_win_valid   (o_win_valid),
    .o_coor_x      (o_coor_x),
    .o_coor_y      (o_coor_y),
    .o_border      (o_border),
    .o_start       (o_start),
    .o_end         (o_end),
    .o_busy        (o_busy),
    .o_err         (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int q[$];
  int n_tests, n_fail;
  int m_aa, m_ab, c_next, n_int, n_cent;
  bit pend_v, pend_abt;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit st, input bit pv, input bit xs,
                      input bit clr, input bit em, input bit abt);
    int c, x, y;
    i_start       = st;
    i_pixel_valid = pv;
    if (em) begin
      q.push_back(c_next);
      c_next++;
    end
    @(negedge i_clk);
    check("shift_en", o_shift_en, xs);
    check("sram_wen", o_sram_wen, !xs);
    check("sram_aa", o_sram_aa, m_aa);
    check("sram_ab", o_sram_ab, m_ab);
    check("win_valid", o_win_valid, pend_v);
    check("err", o_err, pend_abt);
    if (o_win_valid) begin
      check("sb_nonempty", q.size() > 0, 1);
      if (q.size() > 0) begin
        c = q.pop_front();
        x = c % 8;
        y = c / 8;
        n_cent++;
        check("coor_x", o_coor_x, x);
        check("coor_y", o_coor_y, y);
        check("border", o_border, (x < 1 || x > 6 || y < 1 || y > 4));
        check("start", o_start, (x == 0 && y == 0));
        check("end", o_end, (x == 7 && y == 5));
        if (!o_border) n_int++;
      end
    end else begin
      check("end_abort", o_end, pend_abt);
    end
    @(posedge i_clk);
    pend_v   = em;
    pend_abt = abt;
    if (clr) begin
      m_aa = 0;
      m_ab = 2;
    end else if (xs) begin
      m_aa = (m_aa + 1) % 8;
      m_ab = (m_aa + 2) % 8;
    end
    #1;
  endtask

  task automatic run_frame(input bit tog, input int abort_at, input int dcut);
    int p;
    bit done_ab;
    n_int   = 0;
    n_cent  = 0;
    c_next  = 0;
    done_ab = 0;
    step(1, 1, 1, 1, 0, 0);
    p = 2;
    while (p <= 48) begin
      if (tog) step(1, 0, 0, 0, 0, 0);
      if (!done_ab && p == abort_at) begin
        step(1, 1, 1, 1, 0, 1);
        check("busy_restart", o_busy, 1);
        done_ab = 1;
        c_next  = 0;
        p       = 2;
      end else begin
        step(0, 1, 1, 0, p >= 10, 0);
        p++;
      end
    end
    for (int i = 0; i < dcut; i++) step(0, tog, 1, 0, 1, 0);
    if (dcut < 9) begin
      i_rst_n = 1'b0;
      #1;
      check("rst_busy", o_busy, 0);
      check("rst_valid", o_win_valid, 0);
      check("rst_shift", o_shift_en, 0);
      check("rst_wen", o_sram_wen, 1);
      check("rst_end", o_end, 0);
      @(posedge i_clk);
      #2;
      i_rst_n = 1'b1;
      q.delete();
      pend_v   = 0;
      pend_abt = 0;
      m_aa     = 0;
      m_ab     = 0;
      step(0, 0, 0, 0, 0, 0);
      return;
    end
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("busy_after", o_busy, 0);
    check("n_centres", n_cent, 48 + (abort_at > 0 ? abort_at - 10 : 0));
    if (abort_at == 0) check("interior", n_int, 24);
    check("sb_left", q.size(), 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    m_aa          = 0;
    m_ab          = 0;
    pend_v        = 0;
    pend_abt      = 0;
    i_rst_n       = 1'b0;
    i_start       = 1'b0;
    i_pixel_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_busy", o_busy, 0);
    check("reset_valid", o_win_valid, 0);
    check("reset_wen", o_sram_wen, 1);
    check("reset_shift", o_shift_en, 0);
    check("reset_aa", o_sram_aa, 0);
    check("reset_ab", o_sram_ab, 0);
    check("reset_start", o_start, 0);
    check("reset_end", o_end, 0);
    check("reset_err", o_err, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    run_frame(0, 0, 9);
    run_frame(1, 0, 9);
    run_frame(0, 20, 9);
    run_frame(0, 0, 4);
    run_frame(0, 0, 9);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
